// File: rtl/piso_dbuf_shifter_if.sv
// Load/serial bundle for piso_dbuf_shifter.
//   master: drives load_valid, parallel_in, shift_en; observes the rest.
//   slave : the shifter; returns load_ready, serial_out, serial_valid,
//           first_bit, word_done, busy.
interface piso_dbuf_shifter_if #(
  parameter int unsigned WIDTH = 8
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] parallel_in;
  logic             shift_en;
  logic             serial_out;
  logic             serial_valid;
  logic             first_bit;
  logic             word_done;
  logic             busy;

  modport master (
    output load_valid, parallel_in, shift_en,
    input  load_ready, serial_out, serial_valid, first_bit, word_done, busy
  );

  modport slave (
    input  load_valid, parallel_in, shift_en,
    output load_ready, serial_out, serial_valid, first_bit, word_done, busy
  );
endinterface

// File: rtl/piso_dbuf_shifter.sv
// Double-buffered parallel-in/serial-out shifter.
// A one-word holding buffer (hb) sits in front of the shift register (sr) so a
// new word can be accepted while the current one shifts, giving gapless output.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset
//   bus  - slave side of piso_dbuf_shifter_if:
//          load_valid/load_ready/parallel_in : word load handshake
//          shift_en                          : bit-rate strobe
//          serial_out/serial_valid           : serial bit and its qualifier
//          first_bit/word_done               : framing (bit 0 / last bit consumed)
//          busy                              : sr or hb occupied
module piso_dbuf_shifter #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input logic                clk,
  input logic                rst,
  piso_dbuf_shifter_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic {StIdle, StShift} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] hb_q, hb_d;
  logic             hb_full_q, hb_full_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             word_done_q, word_done_d;

  logic             accept;
  logic [WIDTH-1:0] sr_shifted;

  // load_ready depends only on registered state, so accept can never coincide
  // with hb draining (drain needs hb_full = 1, accept needs hb_full = 0).
  assign bus.load_ready = rst & ~hb_full_q;
  assign accept         = bus.load_valid & bus.load_ready;

  assign sr_shifted = MSB_FIRST ? {sr_q[WIDTH-2:0], 1'b0} : {1'b0, sr_q[WIDTH-1:1]};

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    hb_d        = hb_q;
    hb_full_d   = hb_full_q;
    cnt_d       = cnt_q;
    word_done_d = 1'b0;

    if (accept) begin
      hb_d      = bus.parallel_in;
      hb_full_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (hb_full_q) begin
          sr_d      = hb_q;
          hb_full_d = 1'b0;
          cnt_d     = '0;
          state_d   = StShift;
        end
      end
      StShift: begin
        if (bus.shift_en) begin
          if (cnt_q != CntLast) begin
            sr_d  = sr_shifted;
            cnt_d = cnt_q + 1'b1;
          end else begin
            word_done_d = 1'b1;
            if (hb_full_q) begin
              // Reload straight from hb: next word's bit 0 follows with no gap.
              sr_d      = hb_q;
              hb_full_d = 1'b0;
              cnt_d     = '0;
            end else begin
              sr_d    = sr_shifted;
              cnt_d   = '0;
              state_d = StIdle;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      sr_q        <= '0;
      hb_q        <= '0;
      hb_full_q   <= 1'b0;
      cnt_q       <= '0;
      word_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      hb_q        <= hb_d;
      hb_full_q   <= hb_full_d;
      cnt_q       <= cnt_d;
      word_done_q <= word_done_d;
    end
  end

  assign bus.serial_valid = (state_q == StShift);
  assign bus.serial_out   = bus.serial_valid & (MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0]);
  assign bus.first_bit    = bus.serial_valid & (cnt_q == '0);
  assign bus.word_done    = word_done_q;
  assign bus.busy         = bus.serial_valid | hb_full_q;

endmodule

// File: tb/tb_piso_dbuf_shifter.sv
// Bench for piso_dbuf_shifter: an 8-bit MSB-first and a 12-bit LSB-first instance.
// Accepted words are expanded into expected bits on a queue; the monitor pops them
// as the DUT consumes bits and checks serial_out, first_bit and word_done.
module tb_piso_dbuf_shifter;

  logic clk;
  logic rst;

  piso_dbuf_shifter_if #(.WIDTH(8))  b8 ();
  piso_dbuf_shifter_if #(.WIDTH(12)) b12 ();

  piso_dbuf_shifter #(.WIDTH(8), .MSB_FIRST(1'b1)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .bus (b8)
  );

  piso_dbuf_shifter #(.WIDTH(12), .MSB_FIRST(1'b0)) u_dut12 (
    .clk (clk),
    .rst (rst),
    .bus (b12)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic b;
    logic first;
    logic last;
  } sb_t;

  sb_t  q8[$];
  sb_t  q12[$];
  logic exp_done8  = 1'b0;
  logic exp_done12 = 1'b0;

  int checks = 0;
  int errors = 0;

  // Statistics gathered by the monitors; tasks work on deltas.
  logic stream8[$];
  logic stream12[$];
  int   first_pos8[$];
  int   valid_cnt8 = 0, first_cnt8 = 0, done_cnt8 = 0, vrise8 = 0;
  int   valid_cnt12 = 0, first_cnt12 = 0, done_cnt12 = 0;
  logic prev_valid8 = 1'b0;

  // Scoreboard producer/consumer on the active edge (reads pre-edge state).
  always @(posedge clk) begin
    if (!rst) begin
      q8.delete();
      q12.delete();
      exp_done8  = 1'b0;
      exp_done12 = 1'b0;
    end else begin
      exp_done8 = 1'b0;
      if (b8.serial_valid && b8.shift_en && q8.size() > 0) begin
        exp_done8 = q8[0].last;
        void'(q8.pop_front());
      end
      if (b8.load_valid && b8.load_ready)
        for (int i = 0; i < 8; i++)
          q8.push_back('{b: b8.parallel_in[7-i], first: (i == 0), last: (i == 7)});
      exp_done12 = 1'b0;
      if (b12.serial_valid && b12.shift_en && q12.size() > 0) begin
        exp_done12 = q12[0].last;
        void'(q12.pop_front());
      end
      if (b12.load_valid && b12.load_ready)
        for (int i = 0; i < 12; i++)
          q12.push_back('{b: b12.parallel_in[i], first: (i == 0), last: (i == 11)});
    end
  end

  // Monitors sample on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      if (b8.serial_valid) begin
        stream8.push_back(b8.serial_out);
        valid_cnt8++;
        if (!prev_valid8) vrise8++;
        if (b8.first_bit) begin
          first_cnt8++;
          first_pos8.push_back(stream8.size() - 1);
        end
        checks++;
        if (q8.size() == 0) begin
          errors++;
          $display("FAIL sb8_underflow: serial_valid with no expected bit at %0t", $time);
        end else if ({b8.serial_out, b8.first_bit} !== {q8[0].b, q8[0].first}) begin
          errors++;
          $display("FAIL sb8_bit: got out=%b first=%b want out=%b first=%b at %0t",
                   b8.serial_out, b8.first_bit, q8[0].b, q8[0].first, $time);
        end
      end
      if (b8.word_done) done_cnt8++;
      checks++;
      if (b8.word_done !== exp_done8) begin
        errors++;
        $display("FAIL sb8_word_done: got %b want %b at %0t", b8.word_done, exp_done8, $time);
      end
    end
    prev_valid8 = b8.serial_valid;
  end

  always @(negedge clk) begin
    if (rst) begin
      if (b12.serial_valid) begin
        stream12.push_back(b12.serial_out);
        valid_cnt12++;
        if (b12.first_bit) first_cnt12++;
        checks++;
        if (q12.size() == 0) begin
          errors++;
          $display("FAIL sb12_underflow: serial_valid with no expected bit at %0t", $time);
        end else if ({b12.serial_out, b12.first_bit} !== {q12[0].b, q12[0].first}) begin
          errors++;
          $display("FAIL sb12_bit: got out=%b first=%b want out=%b first=%b at %0t",
                   b12.serial_out, b12.first_bit, q12[0].b, q12[0].first, $time);
        end
      end
      if (b12.word_done) done_cnt12++;
      checks++;
      if (b12.word_done !== exp_done12) begin
        errors++;
        $display("FAIL sb12_word_done: got %b want %b at %0t", b12.word_done, exp_done12, $time);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a word until the edge that accepts it; returns 1ns after that edge.
  task automatic send8(input logic [7:0] d);
    bit ok = 1'b0;
    b8.parallel_in = d;
    b8.load_valid  = 1'b1;
    for (int n = 0; n < 60 && !ok; n++) begin
      ok = b8.load_ready;
      step();
    end
    b8.load_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send8_timeout: word %h not accepted, got ready=0 want 1", d);
    end
  endtask

  task automatic send12(input logic [11:0] d);
    bit ok = 1'b0;
    b12.parallel_in = d;
    b12.load_valid  = 1'b1;
    for (int n = 0; n < 60 && !ok; n++) begin
      ok = b12.load_ready;
      step();
    end
    b12.load_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send12_timeout: word %h not accepted, got ready=0 want 1", d);
    end
  endtask

  task automatic wait_idle8();
    int n = 0;
    while (b8.busy && n < 300) begin
      step();
      n++;
    end
    step();
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL wait_idle8_timeout: got busy=%b want 0", b8.busy);
    end
  endtask

  task automatic wait_idle12();
    int n = 0;
    while (b12.busy && n < 300) begin
      step();
      n++;
    end
    step();
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL wait_idle12_timeout: got busy=%b want 0", b12.busy);
    end
  endtask

  task automatic test_reset();
    logic [5:0] o8, o12;
    rst = 1'b0;
    #1;
    o8  = {b8.load_ready, b8.serial_out, b8.serial_valid, b8.first_bit, b8.word_done, b8.busy};
    o12 = {b12.load_ready, b12.serial_out, b12.serial_valid, b12.first_bit, b12.word_done,
           b12.busy};
    checks++;
    if (o8 !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs8: got %b want 000000", o8);
    end
    checks++;
    if (o12 !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs12: got %b want 000000", o12);
    end
    step();
    step();
    rst = 1'b1;
    #1;
    checks++;
    if ({b8.load_ready, b12.load_ready, b8.busy} !== 3'b110) begin
      errors++;
      $display("FAIL reset_release: got ready8/ready12/busy=%b want 110",
               {b8.load_ready, b12.load_ready, b8.busy});
    end
  endtask

  task automatic test_single_word();
    int s0 = stream8.size();
    int v0 = valid_cnt8, f0 = first_cnt8, d0 = done_cnt8;
    logic [7:0] got = '0;
    b8.shift_en = 1'b1;
    send8(8'hA5);
    wait_idle8();
    checks++;
    if (stream8.size() - s0 != 8) begin
      errors++;
      $display("FAIL single_len: got %0d bits want 8", stream8.size() - s0);
    end else begin
      for (int i = 0; i < 8; i++) got[7-i] = stream8[s0+i];
      checks++;
      if (got !== 8'hA5) begin
        errors++;
        $display("FAIL single_stream: got %h want a5", got);
      end
    end
    checks++;
    if ({valid_cnt8 - v0, first_cnt8 - f0, done_cnt8 - d0} !== {32'd8, 32'd1, 32'd1}) begin
      errors++;
      $display("FAIL single_counts: got valid=%0d first=%0d done=%0d want 8 1 1",
               valid_cnt8 - v0, first_cnt8 - f0, done_cnt8 - d0);
    end
    checks++;
    if ({b8.serial_valid, b8.busy} !== 2'b00) begin
      errors++;
      $display("FAIL single_idle: got valid/busy=%b want 00", {b8.serial_valid, b8.busy});
    end
  endtask

  task automatic test_back_to_back();
    int s0 = stream8.size(), p0 = first_pos8.size();
    int v0 = valid_cnt8, d0 = done_cnt8, r0 = vrise8;
    logic [15:0] got = '0;
    b8.shift_en = 1'b1;
    send8(8'hA5);
    send8(8'h3C);
    wait_idle8();
    for (int i = 0; i < 16 && s0 + i < stream8.size(); i++) got[15-i] = stream8[s0+i];
    checks++;
    if (got !== 16'hA53C || stream8.size() - s0 != 16) begin
      errors++;
      $display("FAIL b2b_stream: got %h (%0d bits) want a53c (16 bits)", got,
               stream8.size() - s0);
    end
    checks++;
    if ({valid_cnt8 - v0, done_cnt8 - d0, vrise8 - r0} !== {32'd16, 32'd2, 32'd1}) begin
      errors++;
      $display("FAIL b2b_counts: got valid=%0d done=%0d runs=%0d want 16 2 1",
               valid_cnt8 - v0, done_cnt8 - d0, vrise8 - r0);
    end
    checks++;
    if (first_pos8.size() - p0 != 2) begin
      errors++;
      $display("FAIL b2b_first_count: got %0d want 2", first_pos8.size() - p0);
    end else begin
      checks++;
      if (first_pos8[p0] != s0 || first_pos8[p0+1] != s0 + 8) begin
        errors++;
        $display("FAIL b2b_first_pos: got %0d,%0d want 0,8", first_pos8[p0] - s0,
                 first_pos8[p0+1] - s0);
      end
    end
  endtask

  task automatic test_backpressure();
    int s0 = stream8.size();
    int v0 = valid_cnt8, d0 = done_cnt8, r0 = vrise8;
    int waited = 0;
    logic [23:0] got = '0;
    b8.shift_en = 1'b1;
    send8(8'h5A);
    send8(8'hC3);
    b8.parallel_in = 8'h96;
    b8.load_valid  = 1'b1;
    while (!b8.load_ready && waited < 60) begin
      step();
      waited++;
    end
    checks++;
    if (waited != 7) begin
      errors++;
      $display("FAIL bp_wait: got %0d stalled cycles want 7", waited);
    end
    checks++;
    if (b8.word_done !== 1'b1) begin
      errors++;
      $display("FAIL bp_ready_rise: word_done got %b want 1 when ready rises", b8.word_done);
    end
    step();
    b8.load_valid = 1'b0;
    wait_idle8();
    for (int i = 0; i < 24 && s0 + i < stream8.size(); i++) got[23-i] = stream8[s0+i];
    checks++;
    if (got !== 24'h5AC396 || stream8.size() - s0 != 24) begin
      errors++;
      $display("FAIL bp_stream: got %h (%0d bits) want 5ac396 (24 bits)", got,
               stream8.size() - s0);
    end
    checks++;
    if ({valid_cnt8 - v0, done_cnt8 - d0, vrise8 - r0} !== {32'd24, 32'd3, 32'd1}) begin
      errors++;
      $display("FAIL bp_counts: got valid=%0d done=%0d runs=%0d want 24 3 1",
               valid_cnt8 - v0, done_cnt8 - d0, vrise8 - r0);
    end
  endtask

  task automatic test_pacing();
    int s0, v0, d0;
    logic [7:0] word = 8'hF0;
    b8.shift_en = 1'b0;
    send8(word);
    step();  // sr now loaded; strobe every 3rd edge from here
    s0 = stream8.size();
    v0 = valid_cnt8;
    d0 = done_cnt8;
    for (int k = 1; k <= 30; k++) begin
      b8.shift_en = (k % 3 == 0);
      step();
    end
    b8.shift_en = 1'b1;
    step();
    checks++;
    if (stream8.size() - s0 != 24) begin
      errors++;
      $display("FAIL pace_len: got %0d valid cycles want 24", stream8.size() - s0);
    end else begin
      for (int i = 0; i < 24; i++) begin
        checks++;
        if (stream8[s0+i] !== word[7-i/3]) begin
          errors++;
          $display("FAIL pace_hold: cycle %0d got %b want %b", i, stream8[s0+i], word[7-i/3]);
        end
      end
    end
    checks++;
    if (done_cnt8 - d0 != 1 || valid_cnt8 - v0 != 24) begin
      errors++;
      $display("FAIL pace_counts: got done=%0d valid=%0d want 1 24", done_cnt8 - d0,
               valid_cnt8 - v0);
    end
  endtask

  task automatic test_lsb_first_wide();
    int s0 = stream12.size();
    int v0 = valid_cnt12, f0 = first_cnt12, d0 = done_cnt12;
    logic [11:0] word = 12'h801;
    b12.shift_en = 1'b1;
    send12(word);
    wait_idle12();
    checks++;
    if (stream12.size() - s0 != 12) begin
      errors++;
      $display("FAIL lsb_len: got %0d bits want 12", stream12.size() - s0);
    end else begin
      for (int i = 0; i < 12; i++) begin
        checks++;
        if (stream12[s0+i] !== word[i]) begin
          errors++;
          $display("FAIL lsb_bit: bit %0d got %b want %b", i, stream12[s0+i], word[i]);
        end
      end
    end
    checks++;
    if ({valid_cnt12 - v0, first_cnt12 - f0, done_cnt12 - d0} !== {32'd12, 32'd1, 32'd1}) begin
      errors++;
      $display("FAIL lsb_counts: got valid=%0d first=%0d done=%0d want 12 1 1",
               valid_cnt12 - v0, first_cnt12 - f0, done_cnt12 - d0);
    end
  endtask

  task automatic test_reset_mid_word();
    int s0, d0;
    logic [5:0] o8;
    logic [7:0] got = '0;
    b8.shift_en = 1'b1;
    d0 = done_cnt8;
    send8(8'hA5);
    send8(8'h5A);  // hb full, bit 0 of A5 consumed at this edge
    step();
    step();        // three bits consumed
    checks++;
    if ({b8.load_ready, b8.serial_valid, b8.busy} !== 3'b011) begin
      errors++;
      $display("FAIL rmw_pre: got ready/valid/busy=%b want 011",
               {b8.load_ready, b8.serial_valid, b8.busy});
    end
    rst = 1'b0;
    #1;
    o8 = {b8.load_ready, b8.serial_out, b8.serial_valid, b8.first_bit, b8.word_done, b8.busy};
    checks++;
    if (o8 !== 6'b0) begin
      errors++;
      $display("FAIL rmw_outputs: got %b want 000000", o8);
    end
    step();
    step();
    checks++;
    if (done_cnt8 != d0 || b8.word_done !== 1'b0) begin
      errors++;
      $display("FAIL rmw_no_done: got %0d pulses want 0", done_cnt8 - d0);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({b8.load_ready, b8.busy} !== 2'b10) begin
      errors++;
      $display("FAIL rmw_release: got ready/busy=%b want 10", {b8.load_ready, b8.busy});
    end
    s0 = stream8.size();
    d0 = done_cnt8;
    send8(8'h81);
    wait_idle8();
    for (int i = 0; i < 8 && s0 + i < stream8.size(); i++) got[7-i] = stream8[s0+i];
    checks++;
    if (got !== 8'h81 || stream8.size() - s0 != 8 || done_cnt8 - d0 != 1) begin
      errors++;
      $display("FAIL rmw_fresh: got %h (%0d bits, %0d done) want 81 (8 bits, 1 done)", got,
               stream8.size() - s0, done_cnt8 - d0);
    end
  endtask

  initial begin
    rst             = 1'b0;
    b8.load_valid   = 1'b0;
    b8.parallel_in  = '0;
    b8.shift_en     = 1'b0;
    b12.load_valid  = 1'b0;
    b12.parallel_in = '0;
    b12.shift_en    = 1'b0;

    test_reset();
    test_single_word();
    test_back_to_back();
    test_backpressure();
    test_pacing();
    test_lsb_first_wide();
    test_reset_mid_word();

    checks++;
    if (q8.size() != 0 || q12.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d/%0d expected bits unconsumed want 0/0", q8.size(),
               q12.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
